// File: rtl/peripheral_spram_arbiter.sv
// Round-robin arbiter sharing one 1R1W SRAM between NPORTS req/gnt requesters,
// with optional zero-fill of the whole array after reset.
module peripheral_spram_arbiter #(
    parameter int unsigned NPORTS        = 2,
    parameter int unsigned ABITS         = 8,
    parameter int unsigned DBITS         = 32,
    parameter int unsigned BEBITS        = 4,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NPORTS-1:0]        req_i,
    input  logic [NPORTS-1:0]        we_i,
    input  logic [NPORTS*ABITS-1:0]  addr_i,
    input  logic [NPORTS*BEBITS-1:0] be_i,
    input  logic [NPORTS*DBITS-1:0]  wdata_i,
    output logic [NPORTS-1:0]        gnt_o,
    output logic [NPORTS-1:0]        rvalid_o,
    output logic [DBITS-1:0]         rdata_o,
    output logic                     init_done_o,
    output logic [ABITS-1:0]         mem_waddr_o,
    output logic                     mem_we_o,
    output logic [BEBITS-1:0]        mem_be_o,
    output logic [DBITS-1:0]         mem_din_o,
    output logic                     mem_re_o,
    output logic [ABITS-1:0]         mem_raddr_o,
    input  logic [DBITS-1:0]         mem_dout_i
);
    localparam int unsigned PBITS    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [0:0]  ST_INIT  = 1'b0;
    localparam logic [0:0]  ST_RUN   = 1'b1;
    localparam logic [0:0]  ST_RESET = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    logic [0:0]        state;
    logic [0:0]        state_next;
    logic [ABITS-1:0]  init_cnt;
    logic [PBITS-1:0]  rr_ptr;
    logic [PBITS-1:0]  win;
    logic [PBITS-1:0]  win_inc;
    logic              found;
    logic [NPORTS-1:0] grant;
    logic              sel_we;
    logic [ABITS-1:0]  sel_addr;
    logic [BEBITS-1:0] sel_be;
    logic [DBITS-1:0]  sel_wdata;

    // Two passes: ports at or above rr_ptr first, then the wrapped-around ones.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            if (!found && req_i[k] && (k >= 32'(rr_ptr))) begin
                found = 1'b1;
                win   = PBITS'(k);
            end
        end
        for (int unsigned k = 0; k < NPORTS; k++) begin
            if (!found && req_i[k] && (k < 32'(rr_ptr))) begin
                found = 1'b1;
                win   = PBITS'(k);
            end
        end
    end

    assign win_inc = (32'(win) == NPORTS - 1) ? '0 : win + PBITS'(1);

    always_comb begin
        grant     = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_be    = '0;
        sel_wdata = '0;
        if (state == ST_RUN && found) begin
            for (int unsigned k = 0; k < NPORTS; k++) begin
                if (win == PBITS'(k)) begin
                    grant[k]  = 1'b1;
                    sel_we    = we_i[k];
                    sel_addr  = addr_i[k*ABITS +: ABITS];
                    sel_be    = be_i[k*BEBITS +: BEBITS];
                    sel_wdata = wdata_i[k*DBITS +: DBITS];
                end
            end
        end
    end

    always_comb begin
        mem_we_o    = 1'b0;
        mem_waddr_o = '0;
        mem_be_o    = '0;
        mem_din_o   = '0;
        mem_re_o    = 1'b0;
        mem_raddr_o = '0;
        if (state == ST_INIT) begin
            mem_we_o    = 1'b1;
            mem_waddr_o = init_cnt;
            mem_be_o    = '1;
        end else if (|grant) begin
            if (sel_we) begin
                mem_we_o    = 1'b1;
                mem_waddr_o = sel_addr;
                mem_be_o    = sel_be;
                mem_din_o   = sel_wdata;
            end else begin
                mem_re_o    = 1'b1;
                mem_raddr_o = sel_addr;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_INIT && init_cnt == '1) begin
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_RESET;
            init_cnt <= '0;
            rr_ptr   <= '0;
            rvalid_o <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + ABITS'(1);
            end
            if (|grant) begin
                rr_ptr <= win_inc;
            end
            rvalid_o <= (|grant && !sel_we) ? grant : '0;
        end
    end

    // RAM read data already arrives one cycle after raddr, aligned with rvalid_o.
    assign rdata_o     = mem_dout_i;
    assign gnt_o       = grant;
    assign init_done_o = (state == ST_RUN);

endmodule

// File: tb/tb_peripheral_spram_arbiter.sv
// Scoreboard bench for peripheral_spram_arbiter with a behavioural 1R1W RAM attached.
module tb_peripheral_spram_arbiter;
    localparam int unsigned NP = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_i, we_i;
    logic [15:0] addr_i;
    logic [7:0]  be_i;
    logic [63:0] wdata_i;
    logic [1:0]  gnt_o, rvalid_o;
    logic [31:0] rdata_o;
    logic        init_done_o;
    logic [7:0]  mem_waddr_o, mem_raddr_o;
    logic        mem_we_o, mem_re_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_din_o, mem_dout;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] shadow [0:255];
    logic [31:0] ram [0:255];
    logic        preload;
    int          model_ptr;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    peripheral_spram_arbiter #(
        .NPORTS(2), .ABITS(8), .DBITS(32), .BEBITS(4), .INIT_ON_RESET(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .init_done_o(init_done_o), .mem_waddr_o(mem_waddr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_din_o(mem_din_o),
        .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o), .mem_dout_i(mem_dout)
    );

    // Non-zero power-up contents so the zero-fill is observable.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hA5A5_0000 | 32'(i);
        end else begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) ram[mem_waddr_o][b*8 +: 8] <= mem_din_o[b*8 +: 8];
            end
            if (mem_re_o) mem_dout <= ram[mem_raddr_o];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] model_gnt(input logic [1:0] req, input int ptr);
        for (int i = 0; i < NP; i++) begin
            int p;
            p = (ptr + i) % NP;
            if (req[p]) return 2'(1 << p);
        end
        return 2'b00;
    endfunction

    task automatic op(input logic [1:0] req, input logic [1:0] we,
                      input logic [7:0] a0, input logic [7:0] a1,
                      input logic [3:0] b0, input logic [3:0] b1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] exp_gnt, input string name);
        int          k;
        logic [7:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
        exp_t        e;
        @(posedge clk); #1;
        req_i = req; we_i = we; addr_i = {a1, a0}; be_i = {b1, b0}; wdata_i = {d1, d0};
        @(negedge clk);
        check(name, 64'(gnt_o), 64'(exp_gnt));
        if (exp_gnt != 2'b00) begin
            k  = exp_gnt[1] ? 1 : 0;
            a  = (k == 1) ? a1 : a0;
            be = (k == 1) ? b1 : b0;
            d  = (k == 1) ? d1 : d0;
            if (we[k]) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                e.port = k;
                e.data = shadow[a];
                sbq.push_back(e);
            end
            model_ptr = (k + 1) % NP;
        end
    endtask

    task automatic run_init(input string name);
        int cnt;
        int bad;
        bit done;
        cnt = 0; bad = 0; done = 0;
        while (!done && cnt < 400) begin
            @(negedge clk);
            if (init_done_o) done = 1;
            else begin
                if (gnt_o != 2'b00 || !mem_we_o || mem_waddr_o != 8'(cnt) || mem_din_o != 32'h0)
                    bad++;
                cnt++;
            end
        end
        check({name, "_cycles"}, 64'(cnt), 64'd256);
        check({name, "_fill"}, 64'(bad), 64'd0);
        for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
        model_ptr = 0;
    endtask

    // Monitor: rvalid for a grant in cycle N is registered at the next edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #3;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("rvalid", 64'(rvalid_o), 64'(1) << e.port);
                if (rvalid_o != 2'b00) check("rdata", 64'(rdata_o), 64'(e.data));
            end else if (rvalid_o != 2'b00) begin
                check("unexpected_rvalid", 64'(rvalid_o), 64'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  pend, pwe, eg;
        logic [7:0]  pa [2];
        logic [3:0]  pb [2];
        logic [31:0] pd [2];
        int          wait_cnt [2];
        int          max_wait;
        exp_t        e;

        preload = 1'b1; rst_n = 1'b0;
        req_i = 2'b11; we_i = 2'b00; addr_i = '0; be_i = '0; wdata_i = '0;
        model_ptr = 0;
        @(posedge clk); #1 preload = 1'b0;
        @(negedge clk);
        check("reset_gnt", 64'(gnt_o), 64'd0);
        check("reset_rvalid", 64'(rvalid_o), 64'd0);
        check("reset_init_done", 64'(init_done_o), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Both ports request reads throughout init; nothing may be granted.
        run_init("init1");
        check("init1_done", 64'(init_done_o), 64'd1);
        check("init1_first_gnt", 64'(gnt_o), 64'd1);
        if (gnt_o == 2'b01) begin
            e.port = 0; e.data = 32'h0; sbq.push_back(e); model_ptr = 1;
        end

        for (int i = 0; i < 3; i++) begin
            op(2'b11, 2'b00, 8'h05, 8'hFF, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, "alt_p1");
            op(2'b11, 2'b00, 8'h05, 8'hFF, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, "alt_p0");
        end

        op(2'b01, 2'b01, 8'h10, 8'h00, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 2'b01, "raw_wr");
        op(2'b10, 2'b00, 8'h00, 8'h10, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, "raw_rd");
        op(2'b01, 2'b01, 8'h20, 8'h00, 4'hF, 4'h0, 32'hFFFFFFFF, 32'h0, 2'b01, "be_wr_full");
        op(2'b10, 2'b10, 8'h00, 8'h20, 4'h0, 4'h5, 32'h0, 32'h0, 2'b10, "be_wr_5");
        op(2'b01, 2'b00, 8'h20, 8'h00, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, "be_rd");
        op(2'b10, 2'b10, 8'h00, 8'h20, 4'h0, 4'h0, 32'h0, 32'h12345678, 2'b10, "be0_wr");
        op(2'b01, 2'b00, 8'h20, 8'h00, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, "be0_rd");
        op(2'b10, 2'b00, 8'h00, 8'h10, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, "ptr_to_0");
        op(2'b10, 2'b00, 8'h00, 8'h20, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, "only_p1");
        op(2'b11, 2'b00, 8'h10, 8'h20, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, "ptr_stays_0");

        // Requesters hold their operation until granted.
        pend = 2'b00; max_wait = 0;
        wait_cnt[0] = 0; wait_cnt[1] = 0;
        repeat (1000) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    pend[p]     = 1'b1;
                    pwe[p]      = 1'($urandom_range(0, 1));
                    pa[p]       = 8'h30 + 8'($urandom_range(0, 7));
                    pb[p]       = 4'($urandom);
                    pd[p]       = $urandom;
                    wait_cnt[p] = 0;
                end
            end
            eg = model_gnt(pend, model_ptr);
            op(pend, pwe, pa[0], pa[1], pb[0], pb[1], pd[0], pd[1], eg, "rand_gnt");
            for (int p = 0; p < 2; p++) begin
                if (eg[p]) pend[p] = 1'b0;
                else if (pend[p]) begin
                    wait_cnt[p]++;
                    if (wait_cnt[p] > max_wait) max_wait = wait_cnt[p];
                end
            end
        end
        check("starvation", 64'(max_wait <= NP - 1), 64'd1);
        op(2'b00, 2'b00, 8'h0, 8'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, "idle");

        // Reset while a read grant is in flight: rvalid must be dropped.
        @(posedge clk); #1;
        req_i = 2'b01; we_i = 2'b00; addr_i = 16'h0010;
        @(negedge clk);
        check("pre_reset_gnt", 64'(gnt_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("run_reset_gnt", 64'(gnt_o), 64'd0);
        check("run_reset_done", 64'(init_done_o), 64'd0);
        @(negedge clk);
        check("run_reset_rvalid_drop", 64'(rvalid_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req_i = 2'b00;

        repeat (101) @(negedge clk);
        check("mid_init_addr", 64'(mem_waddr_o), 64'd100);
        rst_n = 1'b0;
        #1;
        check("mid_init_done", 64'(init_done_o), 64'd0);
        check("mid_init_restart", 64'(mem_waddr_o), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_init("init2");
        check("init2_done", 64'(init_done_o), 64'd1);

        op(2'b10, 2'b00, 8'h00, 8'h10, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, "post_init_rd10");
        op(2'b01, 2'b00, 8'h33, 8'h00, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, "post_init_rd33");
        op(2'b00, 2'b00, 8'h0, 8'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, "idle_end");
        @(posedge clk); #4;
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
